// File: rtl/dmem_pkg.sv
// Shared types and constants for the MIPS data memory stage.
package dmem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;

  // Bits needed to index the word array; never below 1 so a 1-word memory still has an index.
  function automatic int word_off_w(input int depth_words);
    return (depth_words > 1) ? $clog2(depth_words) : 1;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: byte enables and store data for stores,
// lane extraction plus sign/zero extension for loads, and alignment checking.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  input  logic        load_unsigned,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  // Store data is replicated across lanes; the byte enables pick the lanes that land.
  always_comb begin
    byte_en    = 4'b0000;
    wdata_sh   = '0;
    rdata_ext  = '0;
    misaligned = 1'b0;
    case (size)
      MEM_BYTE: begin
        byte_en   = 4'b0001 << lane;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = {{24{~load_unsigned & rbyte[7]}}, rbyte};
      end
      MEM_HALF: begin
        misaligned = lane[0];
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        wdata_sh   = {2{wdata[15:0]}};
        rdata_ext  = {{16{~load_unsigned & rhalf[15]}}, rhalf};
      end
      MEM_WORD: begin
        misaligned = |lane;
        byte_en    = 4'b1111;
        wdata_sh   = wdata;
        rdata_ext  = rword;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Single-cycle MIPS data memory: combinational loads, edge-committed byte/half/word stores,
// fault flags, sticky error and saturating store counter. DMEM_MMIO_EN adds one MMIO word register.
module data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      inpAddress,
  input  logic [31:0]      inpWriteData,
  input  logic             inpMemRead,
  input  logic             inpMemWrite,
  input  logic [1:0]       inpMemSize,
  input  logic             inpLoadUnsigned,
  output logic [31:0]      outReadData,
  output logic             outMisaligned,
  output logic             outOutOfRange,
  output logic             outErrorSticky,
  output logic [CNT_W-1:0] outStoreCount,
  output logic [31:0]      outMmioReg
);

  localparam int          WOFF_W     = word_off_w(DEPTH_WORDS);
  localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [31:0]      mem_d [DEPTH_WORDS];
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic              access, is_mmio, in_range, lane_mis, misaligned, fault, commit;
  logic [WOFF_W-1:0] widx;
  logic [31:0]       rword, wdata_sh, rdata_ext;
  logic [3:0]        byte_en;

  assign access   = inpMemRead | inpMemWrite;
  assign in_range = inpAddress < BYTE_LIMIT;
  assign widx     = inpAddress[WOFF_W+1:2];

`ifdef DMEM_MMIO_EN
  logic [31:0] mmio_q, mmio_d;

  assign is_mmio = (inpAddress == MMIO_ADDR);

  always_comb begin
    mmio_d = mmio_q;
    if (commit && is_mmio) mmio_d = inpWriteData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mmio_q <= '0;
    else       mmio_q <= mmio_d;
  end

  assign outMmioReg = mmio_q;
`else
  assign is_mmio    = 1'b0;
  assign outMmioReg = '0;
`endif

  always_comb begin
    rword = '0;
    if (is_mmio)       rword = outMmioReg;
    else if (in_range) rword = mem_q[widx];
  end

  dmem_lane_align u_align (
    .size          (inpMemSize),
    .lane          (inpAddress[1:0]),
    .wdata         (inpWriteData),
    .rword         (rword),
    .load_unsigned (inpLoadUnsigned),
    .byte_en       (byte_en),
    .wdata_sh      (wdata_sh),
    .rdata_ext     (rdata_ext),
    .misaligned    (lane_mis)
  );

  // The MMIO register is word-only; any narrower access to it counts as misaligned.
  assign misaligned     = lane_mis | (is_mmio & (inpMemSize != MEM_WORD));
  assign outMisaligned  = access & misaligned;
  assign outOutOfRange  = access & ~in_range & ~is_mmio;
  assign fault          = outMisaligned | outOutOfRange;
  assign commit         = inpMemWrite & ~fault;
  assign outReadData    = (inpMemRead & ~fault) ? rdata_ext : '0;
  assign outErrorSticky = err_q;
  assign outStoreCount  = cnt_q;

  always_comb begin
    mem_d = mem_q;
    if (commit && !is_mmio) begin
      for (int b = 0; b < 4; b++)
        if (byte_en[b]) mem_d[widx][8*b +: 8] = wdata_sh[8*b +: 8];
    end
  end

  always_comb begin
    err_d = err_q | fault;
    cnt_d = cnt_q;
    if (commit && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: the driver pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares while an access is presented.
`timescale 1ns/1ps
module tb_data_memory;

  localparam int DEPTH = 256;
  localparam int CW    = 8;   // narrow counter so saturation is reachable in a few hundred stores

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   inpAddress = '0, inpWriteData = '0;
  logic          inpMemRead = 1'b0, inpMemWrite = 1'b0, inpLoadUnsigned = 1'b0;
  logic [1:0]    inpMemSize = 2'd2;
  logic [31:0]   outReadData, outMmioReg;
  logic          outMisaligned, outOutOfRange, outErrorSticky;
  logic [CW-1:0] outStoreCount;

  data_memory #(.DEPTH_WORDS(DEPTH), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .inpAddress      (inpAddress),
    .inpWriteData    (inpWriteData),
    .inpMemRead      (inpMemRead),
    .inpMemWrite     (inpMemWrite),
    .inpMemSize      (inpMemSize),
    .inpLoadUnsigned (inpLoadUnsigned),
    .outReadData     (outReadData),
    .outMisaligned   (outMisaligned),
    .outOutOfRange   (outOutOfRange),
    .outErrorSticky  (outErrorSticky),
    .outStoreCount   (outStoreCount),
    .outMmioReg      (outMmioReg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   rdata;
    logic          mis;
    logic          oor;
    logic          sticky;
    logic [CW-1:0] cnt;
    logic [31:0]   mmio;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    total = 0;
  int    bad   = 0;

  logic          m_sticky = 1'b0;
  logic [CW-1:0] m_cnt    = '0;
  logic [31:0]   m_mmio   = '0;
  logic [31:0]   last_wd  = '0;

  task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h", nm, f, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t  e;
    string n;
    if (q.size() > 0) begin
      e = q.pop_front();
      n = nq.pop_front();
      chk(n, "rdata",  outReadData, e.rdata);
      chk(n, "mis",    32'(outMisaligned), 32'(e.mis));
      chk(n, "oor",    32'(outOutOfRange), 32'(e.oor));
      chk(n, "sticky", 32'(outErrorSticky), 32'(e.sticky));
      chk(n, "cnt",    32'(outStoreCount), 32'(e.cnt));
      chk(n, "mmio",   outMmioReg, e.mmio);
    end
  end

  // One cycle of stimulus; er/em/eo are the hand-computed combinational results.
  task automatic step(input string nm, input logic rst, input logic [31:0] a, input logic [31:0] wd,
                      input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] er, input logic em, input logic eo);
    exp_t e;
    @(posedge clk); #1;
    reset = rst; inpAddress = a; inpWriteData = wd; inpMemRead = rd; inpMemWrite = wr;
    inpMemSize = sz; inpLoadUnsigned = uns;
    if (rst) begin m_sticky = 1'b0; m_cnt = '0; m_mmio = '0; end
    e.rdata = er; e.mis = em; e.oor = eo;
    e.sticky = m_sticky; e.cnt = m_cnt; e.mmio = m_mmio;
    q.push_back(e);
    nq.push_back(nm);
    if (!rst) begin
      if ((rd | wr) & (em | eo)) m_sticky = 1'b1;
      if (wr & ~(em | eo)) begin
        if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + CW'(1);
        if (a == 32'hFFFF_FFF0) m_mmio = wd;
        last_wd = wd;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //    name        rst addr          wdata         rd wr sz    u  exp_rdata     mis oor
    step("rst",       1, 32'h10,       32'h0,        1, 0, 2'd2, 0, 32'h0,        0, 0);
    step("rst_rel",   0, 32'h10,       32'h0,        0, 0, 2'd2, 0, 32'h0,        0, 0);
    step("st_w10",    0, 32'h10,       32'hDEADBEEF, 0, 1, 2'd2, 0, 32'h0,        0, 0);
    step("ld_w10",    0, 32'h10,       32'h0,        1, 0, 2'd2, 0, 32'hDEADBEEF, 0, 0);
    step("ld_b13s",   0, 32'h13,       32'h0,        1, 0, 2'd0, 0, 32'hFFFFFFDE, 0, 0);
    step("ld_b13u",   0, 32'h13,       32'h0,        1, 0, 2'd0, 1, 32'h000000DE, 0, 0);
    step("ld_h10s",   0, 32'h10,       32'h0,        1, 0, 2'd1, 0, 32'hFFFFBEEF, 0, 0);
    step("ld_h12u",   0, 32'h12,       32'h0,        1, 0, 2'd1, 1, 32'h0000DEAD, 0, 0);
    step("st_b11",    0, 32'h11,       32'h00000012, 0, 1, 2'd0, 0, 32'h0,        0, 0);
    step("ld_w10b",   0, 32'h10,       32'h0,        1, 0, 2'd2, 0, 32'hDEAD12EF, 0, 0);
    step("st_h22",    0, 32'h22,       32'h0000ABCD, 0, 1, 2'd1, 0, 32'h0,        0, 0);
    step("ld_w20",    0, 32'h20,       32'h0,        1, 0, 2'd2, 0, 32'hABCD0000, 0, 0);
    step("rw_w10",    0, 32'h10,       32'h11223344, 1, 1, 2'd2, 0, 32'hDEAD12EF, 0, 0);
    step("ld_w10c",   0, 32'h10,       32'h0,        1, 0, 2'd2, 0, 32'h11223344, 0, 0);
    step("st_w02",    0, 32'h02,       32'hFFFFFFFF, 0, 1, 2'd2, 0, 32'h0,        1, 0);
    step("ld_w00",    0, 32'h00,       32'h0,        1, 0, 2'd2, 0, 32'h0,        0, 0);
    step("st_h13",    0, 32'h13,       32'h0000FFFF, 0, 1, 2'd1, 0, 32'h0,        1, 0);
    step("ld_h11",    0, 32'h11,       32'h0,        1, 0, 2'd1, 0, 32'h0,        1, 0);
    step("ld_sz3",    0, 32'h10,       32'h0,        1, 0, 2'd3, 0, 32'h0,        1, 0);
    step("ld_oor",    0, 32'h400,      32'h0,        1, 0, 2'd2, 0, 32'h0,        0, 1);
    step("st_oor",    0, 32'h400,      32'h12345678, 0, 1, 2'd2, 0, 32'h0,        0, 1);
    step("st_3fc",    0, 32'h3FC,      32'hCAFEF00D, 0, 1, 2'd2, 0, 32'h0,        0, 0);
    step("ld_3fc",    0, 32'h3FC,      32'h0,        1, 0, 2'd2, 0, 32'hCAFEF00D, 0, 0);
    step("ld_b3ff",   0, 32'h3FF,      32'h0,        1, 0, 2'd0, 0, 32'hFFFFFFCA, 0, 0);
    step("idle_bad",  0, 32'h02,       32'h0,        0, 0, 2'd3, 0, 32'h0,        0, 0);
    step("ld_w10d",   0, 32'h10,       32'h0,        1, 0, 2'd2, 0, 32'h11223344, 0, 0);
`ifdef DMEM_MMIO_EN
    step("st_mmio",   0, 32'hFFFFFFF0, 32'h000000A5, 0, 1, 2'd2, 0, 32'h0,        0, 0);
    step("ld_mmio",   0, 32'hFFFFFFF0, 32'h0,        1, 0, 2'd2, 0, 32'h000000A5, 0, 0);
    step("st_mmio_b", 0, 32'hFFFFFFF0, 32'h000000FF, 0, 1, 2'd0, 0, 32'h0,        1, 0);
    step("ld_mmio2",  0, 32'hFFFFFFF0, 32'h0,        1, 0, 2'd2, 0, 32'h000000A5, 0, 0);
`else
    step("ld_mmio",   0, 32'hFFFFFFF0, 32'h0,        1, 0, 2'd2, 0, 32'h0,        0, 1);
    step("st_mmio",   0, 32'hFFFFFFF0, 32'h000000A5, 0, 1, 2'd2, 0, 32'h0,        0, 1);
`endif
    // Drive the counter up to all-ones, then three more stores that must not wrap it.
    for (int i = 0; i < 400 && m_cnt != {CW{1'b1}}; i++)
      step("st_fill", 0, 32'h40, 32'h5A5A0000 + 32'(i), 0, 1, 2'd2, 0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("st_sat", 0, 32'h40, 32'hC0DE0000 + 32'(i), 0, 1, 2'd2, 0, 32'h0, 0, 0);
    step("ld_sat",    0, 32'h40,       32'h0,        1, 0, 2'd2, 0, last_wd,      0, 0);
    if (m_cnt != {CW{1'b1}}) begin
      bad++; total++;
      $display("FAIL sat_model got=%h want=%h", m_cnt, {CW{1'b1}});
    end
    // Reset asserted mid-cycle: outputs and memory clear at once; a store under reset is dropped.
    step("rst_mid",   1, 32'h10,       32'h0,        1, 0, 2'd2, 0, 32'h0,        0, 0);
    step("rst_st",    1, 32'h30,       32'h55AA55AA, 1, 1, 2'd2, 0, 32'h0,        0, 0);
    step("post_rst",  0, 32'h30,       32'h0,        1, 0, 2'd2, 0, 32'h0,        0, 0);
    step("post_w10",  0, 32'h10,       32'h0,        1, 0, 2'd2, 0, 32'h0,        0, 0);
    @(posedge clk); #1;
    inpMemRead = 1'b0; inpMemWrite = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Data memory stage directly downstream of arithmetic_logic_unit in the single-cycle MIPS datapath. aluResult drives the byte address; register-file rt data is the store data.
- Supports byte, half and word loads and stores, with sign or zero extension on loads.
- Flags misaligned and out-of-range accesses, keeps a sticky error flag and a saturating store counter.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; byte address range is 0 .. 4*DEPTH_WORDS-1.
- CNT_W, 16, width of the store counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- inpAddress  input  32  byte address, from aluResult.
- inpWriteData  input  32  store data.
- inpMemRead  input  1  load strobe.
- inpMemWrite  input  1  store strobe.
- inpMemSize  input  2  access size: 0 byte, 1 half, 2 word; 3 is illegal and treated as misaligned.
- inpLoadUnsigned  input  1  1 = zero-extend loads, 0 = sign-extend loads.
- outReadData  output  32  load result, combinational.
- outMisaligned  output  1  combinational; set when the current access is misaligned.
- outOutOfRange  output  1  combinational; set when the current access is out of range.
- outErrorSticky  output  1  set by any faulting access; cleared only by reset.
- outStoreCount  output  CNT_W  count of committed stores; saturates at all-ones.
- outMmioReg  output  32  MMIO register (see Optional Feature).

Behaviour:
- Reset (asynchronous): memory array, outErrorSticky, outStoreCount and outMmioReg all go to 0. Reset asserted mid-store suppresses that store.
- Byte order is little-endian within a word.
- Word index is inpAddress[31:2]. Byte lane is inpAddress[1:0].
- Misaligned when any of:
  - half access with inpAddress[0]=1
  - word access with inpAddress[1:0]!=0
  - size=3
- Out of range when inpAddress >= 4*DEPTH_WORDS (except the MMIO address when the feature is enabled).
- Fault = (inpMemRead | inpMemWrite) & (misaligned | out of range). Both flags are driven combinationally whenever either strobe is high, and forced to 0 when neither strobe is high.
- Loads are combinational, zero-latency:
  - Byte: selected lane, extended from bit 7.
  - Half: lanes {1,0} or {3,2}, extended from bit 15.
  - Word: raw word.
  - outReadData = 0 when inpMemRead=0 or the access faults.
- Stores commit on the rising edge when inpMemWrite=1, no fault and reset=0:
  - Only the addressed byte lanes are written; other lanes are untouched.
  - A faulting store writes nothing and does not increment the counter.
- Simultaneous read and write to the same word: outReadData shows the pre-edge contents; new data is visible the cycle after the edge.
- inpMemRead and inpMemWrite together is legal; both actions occur.
- outErrorSticky is set on the edge after any faulting cycle and stays 1 until reset.
- outStoreCount increments by 1 per committed store and holds at 2^CNT_W-1 (no wrap).

Optional Feature:
- Macro: DMEM_MMIO_EN.
- Defined:
  - Word address 32'hFFFF_FFF0 maps to a 32-bit register driving outMmioReg.
  - Word stores to it commit and count. Byte and half stores to it are misaligned faults.
  - Word loads from it return the register value.
- Not defined: that address is out of range like any other, and outMmioReg is tied to 0.

Decomposition:
- Package dmem_pkg:
  - mem_size_t enum: MEM_BYTE=2'd0, MEM_HALF=2'd1, MEM_WORD=2'd2.
  - MMIO_ADDR = 32'hFFFF_FFF0.
  - Helper constant for word-offset width.
- Sub-module dmem_lane_align (combinational):
  - From size and address lane: produces the 4-bit byte-enable and lane-shifted store data.
  - Extracts and extends load data.
  - Reports misalignment.
- data_memory keeps the array, range check, counters and sticky flag.

Test Plan:
- Word store 32'hDEAD_BEEF at address 0x10, then word load from 0x10 -> outReadData=32'hDEAD_BEEF, outStoreCount=1.
- Byte loads from 0x13 after the above:
  - inpLoadUnsigned=0 -> 32'hFFFF_FFDE.
  - inpLoadUnsigned=1 -> 32'h0000_00DE.
  - Half load from 0x10, signed -> 32'hFFFF_BEEF.
- Byte store 8'h12 at 0x11 -> word at 0x10 reads 32'hDEAD_12EF; other lanes unchanged.
- Word store to 0x02 -> outMisaligned=1, no write, count unchanged, outErrorSticky=1 the next cycle and stays 1 until reset.
- Word load from address 4*DEPTH_WORDS -> outOutOfRange=1, outReadData=0.
- With the store counter preloaded near saturation, 3 stores -> count holds at 16'hFFFF.
- With DMEM_MMIO_EN defined: word store 32'h0000_00A5 to 32'hFFFF_FFF0 -> outMmioReg=32'h0000_00A5.
- Assert reset asynchronously mid-cycle -> all outputs 0 immediately and memory reads 0.
